// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing single-port dmem between core (A) and debug loader (B)
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [3:0]    a_wstrb,
  output logic          a_gnt,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic [3:0]    b_wstrb,
  output logic          b_gnt,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nxt;
  logic          last_b;
  logic          own_b;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic [CW-1:0] cnt;
  logic          win_a, win_b, wait_end;

  // On a tie the port that did not win last time gets the grant.
  assign win_a    = a_req & (~b_req | last_b);
  assign win_b    = b_req & ~win_a;
  assign wait_end = (state == WAIT) && (cnt == CW'(MEM_LAT - 1));

  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign mem_wstrb = cmd_wstrb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_req | b_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    busy   = (state != IDLE);
    case (state)
      IDLE: begin
        a_gnt = win_a;
        b_gnt = win_b;
      end
      ISSUE: begin
        mem_en = 1'b1;
        mem_we = cmd_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b    <= 1'b1;
      own_b     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wstrb <= '0;
      cnt       <= '0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      if (state == IDLE && (a_req | b_req)) begin
        own_b     <= win_b;
        last_b    <= win_b;
        cmd_we    <= win_b ? b_we    : a_we;
        cmd_addr  <= win_b ? b_addr  : a_addr;
        cmd_wdata <= win_b ? b_wdata : a_wdata;
        cmd_wstrb <= win_b ? b_wstrb : a_wstrb;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      a_done <= wait_end & ~own_b;
      b_done <= wait_end &  own_b;
      // Read data is captured in the last WAIT cycle, when dmem output is valid.
      if (wait_end && !own_b && !cmd_we) a_rdata <= mem_rdata;
      if (wait_end &&  own_b && !cmd_we) b_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_dmem_arbiter;

  logic clk, rst_n;
  int   n_checks, n_errors;

  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, a_rdata, b_rdata;
  logic [3:0]  a_wstrb, b_wstrb, m1_wstrb;
  logic        a_gnt, a_done, b_gnt, b_done, m1_en, m1_we, busy1;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;

  logic        d2_a_req, d2_a_we, d2_b_req, d2_b_we;
  logic [31:0] d2_a_addr, d2_a_wdata, d2_b_addr, d2_b_wdata, d2_a_rdata, d2_b_rdata;
  logic [3:0]  d2_a_wstrb, d2_b_wstrb, m2_wstrb;
  logic        d2_a_gnt, d2_a_done, d2_b_gnt, d2_b_done, m2_en, m2_we, busy2;
  logic [31:0] m2_addr, m2_wdata, m2_rdata;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_wstrb(m1_wstrb), .mem_rdata(m1_rdata), .busy(busy1)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut2 (
    .clk(clk), .reset(rst_n),
    .a_req(d2_a_req), .a_we(d2_a_we), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata), .a_wstrb(d2_a_wstrb),
    .a_gnt(d2_a_gnt), .a_done(d2_a_done), .a_rdata(d2_a_rdata),
    .b_req(d2_b_req), .b_we(d2_b_we), .b_addr(d2_b_addr), .b_wdata(d2_b_wdata), .b_wstrb(d2_b_wstrb),
    .b_gnt(d2_b_gnt), .b_done(d2_b_done), .b_rdata(d2_b_rdata),
    .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
    .mem_wstrb(m2_wstrb), .mem_rdata(m2_rdata), .busy(busy2)
  );

  // Memory models: read data only valid exactly MEM_LAT cycles after en, poison otherwise
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic        v1;
  logic [31:0] q1;
  logic [2:0]  v2;
  logic [31:0] p2 [0:2];

  always @(posedge clk) begin
    v1 <= m1_en & ~m1_we;
    if (m1_en) begin
      q1 <= mem1[m1_addr[9:2]];
      if (m1_we)
        for (int i = 0; i < 4; i++)
          if (m1_wstrb[i]) mem1[m1_addr[9:2]][8*i +: 8] <= m1_wdata[8*i +: 8];
    end
  end
  assign m1_rdata = v1 ? q1 : 32'hbad0bad0;

  always @(posedge clk) begin
    v2    <= {v2[1:0], m2_en & ~m2_we};
    p2[0] <= mem2[m2_addr[9:2]];
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign m2_rdata = v2[2] ? p2[2] : 32'hbad0bad0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem2[i] = '0; end
    mem1[24] = 32'd7;      // addr 96
    mem1[16] = 32'h55;     // addr 0x40
    mem2[64] = 32'h1234;   // addr 0x100
    v1 = 1'b0; v2 = '0; q1 = '0;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_wstrb = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0;
    d2_a_req = 0; d2_a_we = 0; d2_a_addr = 0; d2_a_wdata = 0; d2_a_wstrb = 0;
    d2_b_req = 0; d2_b_we = 0; d2_b_addr = 0; d2_b_wdata = 0; d2_b_wstrb = 0;
    nxt(); nxt(); #1;
    check("rst_busy", busy1, 0);
    check("rst_mem_en", m1_en, 0);
    check("rst_mem_addr", m1_addr, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_done", {a_done, b_done}, 0);

    // Test 1: A read addr 96
    nxt(); rst_n = 1;
    a_req = 1; a_we = 0; a_addr = 96; #1;
    check("t1_a_gnt", a_gnt, 1);
    check("t1_b_gnt", b_gnt, 0);
    nxt(); a_req = 0; #1;
    check("t1_mem_en", m1_en, 1);
    check("t1_mem_we", m1_we, 0);
    check("t1_mem_addr", m1_addr, 96);
    check("t1_busy", busy1, 1);
    nxt(); #1;
    check("t1_early_done", a_done, 0);
    check("t1_en_wait", m1_en, 0);
    nxt(); #1;
    check("t1_a_done", a_done, 1);
    check("t1_a_rdata", a_rdata, 7);
    check("t1_b_quiet", {b_done, b_gnt}, 0);
    check("t1_idle", busy1, 0);
    nxt(); #1;
    check("t1_done_pulse", a_done, 0);

    // Test 2: A write addr 32
    a_req = 1; a_we = 1; a_addr = 32; a_wdata = 25; a_wstrb = 4'hf; #1;
    check("t2_a_gnt", a_gnt, 1);
    nxt(); a_req = 0; #1;
    check("t2_mem_en_we", {m1_en, m1_we}, 2'b11);
    check("t2_mem_addr", m1_addr, 32);
    check("t2_mem_wdata", m1_wdata, 25);
    check("t2_mem_wstrb", m1_wstrb, 4'hf);
    nxt(); nxt(); #1;
    check("t2_a_done", a_done, 1);
    check("t2_a_rdata_held", a_rdata, 7);
    check("t2_mem_written", mem1[8], 25);

    // Test 3: both requesting from reset release
    nxt(); rst_n = 0; a_we = 0; #1;
    nxt(); rst_n = 1;
    a_req = 1; a_addr = 96; b_req = 1; b_we = 0; b_addr = 32'h40;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) nxt();
      if (c == 10) begin a_req = 0; b_req = 0; end
      #1;
      check($sformatf("t3_a_gnt_c%0d", c), a_gnt, (c == 0 || c == 6));
      check($sformatf("t3_b_gnt_c%0d", c), b_gnt, (c == 3 || c == 9));
      check($sformatf("t3_a_done_c%0d", c), a_done, (c == 3 || c == 9));
      check($sformatf("t3_b_done_c%0d", c), b_done, (c == 6 || c == 12));
      if (c == 6)  check("t3_b_rdata", b_rdata, 32'h55);
      if (c == 9)  check("t3_a_rdata", a_rdata, 7);
    end

    // Test 4: A back-to-back, B idle
    nxt(); a_req = 1; a_addr = 96;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) nxt();
      if (c == 7) a_req = 0;
      #1;
      check($sformatf("t4_a_gnt_c%0d", c), a_gnt, (c == 0 || c == 3 || c == 6));
      check($sformatf("t4_a_done_c%0d", c), a_done, (c == 3 || c == 6 || c == 9));
      check($sformatf("t4_mem_en_c%0d", c), m1_en, (c == 1 || c == 4 || c == 7));
    end

    // Test 5: MEM_LAT=3, B read addr 0x100
    nxt(); d2_b_req = 1; d2_b_we = 0; d2_b_addr = 32'h100; #1;
    check("t5_b_gnt", d2_b_gnt, 1);
    check("t5_a_gnt", d2_a_gnt, 0);
    for (int c = 1; c <= 6; c++) begin
      nxt();
      d2_b_req = 0;
      #1;
      check($sformatf("t5_mem_en_c%0d", c), m2_en, (c == 1));
      check($sformatf("t5_busy_c%0d", c), busy2, (c >= 1 && c <= 4));
      check($sformatf("t5_b_done_c%0d", c), d2_b_done, (c == 5));
      if (c == 1) check("t5_mem_addr", m2_addr, 32'h100);
      if (c == 5) check("t5_b_rdata", d2_b_rdata, 32'h1234);
    end

    // Test 6: reset during WAIT of an A write
    nxt(); a_req = 1; a_we = 1; a_addr = 48; a_wdata = 32'h99; a_wstrb = 4'h3; #1;
    check("t6_a_gnt", a_gnt, 1);
    nxt(); a_req = 0; #1;
    check("t6_mem_wstrb", m1_wstrb, 4'h3);
    nxt(); #1;
    check("t6_busy_wait", busy1, 1);
    rst_n = 0; #1;
    check("t6_rst_busy", busy1, 0);
    check("t6_rst_mem", {m1_en, m1_we, m1_wstrb}, 0);
    check("t6_rst_addr", m1_addr, 0);
    check("t6_rst_wdata", m1_wdata, 0);
    check("t6_rst_rdata", a_rdata, 0);
    nxt(); rst_n = 1;
    a_req = 1; a_we = 0; a_addr = 96; b_req = 1; b_addr = 32'h40;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) nxt();
      if (c == 1) begin a_req = 0; b_req = 0; end
      #1;
      check($sformatf("t6_a_gnt_c%0d", c), a_gnt, (c == 0));
      check($sformatf("t6_b_gnt_c%0d", c), b_gnt, 0);
      check($sformatf("t6_a_done_c%0d", c), a_done, (c == 3));
      check($sformatf("t6_b_done_c%0d", c), b_done, 0);
      check($sformatf("t6_mem_en_c%0d", c), m1_en, (c == 1));
    end
    check("t6_a_rdata", a_rdata, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
